// File: rtl/lii_pkg.sv
// Shared LII constants and helpers.
//   LII_ID_W     : width of the src/dst stream identifiers
//   DROP_W       : width of the dropped-beat counter
//   DROP_SAT     : value the dropped-beat counter saturates at
//   drop_sat_add : saturating add of a small increment to the drop counter
package lii_pkg;

  localparam int                LII_ID_W = 8;
  localparam int                DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

  // Increment is at most the number of phy channels (<= 4), so 3 bits suffice.
  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                     input logic [2:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-2){1'b0}}, inc};
    return sum[DROP_W] ? DROP_SAT : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/lii_in_demux_if.sv
// Bus bundle between the LII phy channels, the demux and the kernel streams.
//   lii_in_*  : P phy channels (data, valid/ready, src/dst IDs)
//   k_*       : NIN kernel-side streams (data, valid/ready)
// master = phy/kernel environment side, slave = the demux.
interface lii_in_demux_if
  import lii_pkg::*;
#(
  parameter int NIN = 4,
  parameter int P   = 2,
  parameter int PW  = 64,
  parameter int DW  = 8
) ();

  logic [P*PW-1:0]       lii_in_tdata;
  logic [P-1:0]          lii_in_tvalid;
  logic [P-1:0]          lii_in_tready;
  logic [P*LII_ID_W-1:0] lii_in_src;
  logic [P*LII_ID_W-1:0] lii_in_dst;
  logic [NIN*DW-1:0]     k_tdata;
  logic [NIN-1:0]        k_tvalid;
  logic [NIN-1:0]        k_tready;

  modport master (
    output lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, k_tready,
    input  lii_in_tready, k_tdata, k_tvalid
  );

  modport slave (
    input  lii_in_tdata, lii_in_tvalid, lii_in_src, lii_in_dst, k_tready,
    output lii_in_tready, k_tdata, k_tvalid
  );

endinterface

// File: rtl/lii_sync_fifo.sv
// Single-clock FIFO for one kernel stream.
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   i_push, i_data  : write request/data; ignored while full
//   o_full          : no room for a push this cycle (a same-cycle pop does not help)
//   i_pop           : read request; ignored while empty
//   o_valid, o_data : head-of-queue present / head data (stable until popped)
module lii_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic          o_full,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~w_empty;
  assign o_valid   = ~w_empty;
  assign o_data    = r_mem[r_rd[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lii_in_demux.sv
// Demultiplexes P LII phy channels onto NIN kernel streams by destination ID.
//   aclk, arstn : clock, async active-low reset
//   bus         : phy channels in, kernel streams out (lii_in_demux_if slave)
//   ce          : kernel clock enable, low while a ready stream is empty
//   drop_count  : saturating count of beats with an unmapped dst
module lii_in_demux
  import lii_pkg::*;
#(
  parameter int         NIN      = 4,
  parameter int         P        = 2,
  parameter int         PW       = 64,
  parameter int         DW       = 8,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] DST_BASE = 8'h00
) (
  input  logic              aclk,
  input  logic              arstn,
  lii_in_demux_if.slave     bus,
  output logic              ce,
  output logic [DROP_W-1:0] drop_count
);

  localparam int PTRW = (P > 1) ? $clog2(P) : 1;

  logic                r_rdy_en;     // low in reset and until the first edge after it
  logic [PTRW-1:0]     r_ptr [NIN];  // per-stream round-robin start channel
  logic [DROP_W-1:0]   r_drop;
  logic [LII_ID_W-1:0] w_idx [P];
  logic [P-1:0]        w_mapped;
  logic [P-1:0]        w_rdy;
  logic [P-1:0]        w_acc;
  logic [NIN-1:0]      w_push;
  logic [NIN-1:0]      w_full;
  logic [NIN-1:0]      w_kvalid;
  logic [DW-1:0]       w_push_data [NIN];
  logic [DW-1:0]       w_kdata [NIN];
  logic [PTRW-1:0]     w_grant [NIN];
  logic [2:0]          w_drop_inc;
  logic                w_unused;

  // src and the packing bits above DW carry nothing for the kernel.
  assign w_unused = ^{bus.lii_in_src, bus.lii_in_tdata};

  // Destination decode; the 8-bit wrap makes dst below DST_BASE look out of range.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      w_idx[p]    = bus.lii_in_dst[p*LII_ID_W +: LII_ID_W] - DST_BASE;
      w_mapped[p] = (w_idx[p] < LII_ID_W'(NIN));
    end
  end

  // Per-stream round-robin. A channel is offered ready when no valid requester
  // for the same stream precedes it from the pointer; its own tvalid is not
  // consulted, so tready never depends on it.
  always_comb begin
    logic seen_v;
    int   ch_v;
    w_rdy = '0;
    for (int s = 0; s < NIN; s++) begin
      w_push[s]      = 1'b0;
      w_push_data[s] = '0;
      w_grant[s]     = r_ptr[s];
      seen_v         = 1'b0;
      for (int k = 0; k < P; k++) begin
        ch_v = int'(r_ptr[s]) + k;
        if (ch_v >= P) ch_v = ch_v - P;
        else           ch_v = ch_v;
        if (w_mapped[ch_v] && (w_idx[ch_v] == LII_ID_W'(s)) && !seen_v) begin
          w_rdy[ch_v] = r_rdy_en & ~w_full[s];
          if (bus.lii_in_tvalid[ch_v]) begin
            seen_v         = 1'b1;
            w_push[s]      = r_rdy_en & ~w_full[s];
            w_push_data[s] = bus.lii_in_tdata[ch_v*PW +: DW];
            w_grant[s]     = PTRW'(ch_v);
          end else begin
            seen_v = 1'b0;
          end
        end else begin
          seen_v = seen_v;
        end
      end
    end
    // Unmapped beats are always sunk.
    for (int p = 0; p < P; p++) begin
      if (!w_mapped[p]) w_rdy[p] = r_rdy_en;
      else              w_rdy[p] = w_rdy[p];
    end
  end

  assign w_acc              = bus.lii_in_tvalid & w_rdy;
  assign bus.lii_in_tready  = w_rdy;

  // Number of unmapped beats accepted this cycle.
  always_comb begin
    w_drop_inc = 3'd0;
    for (int p = 0; p < P; p++) begin
      if (w_acc[p] && !w_mapped[p]) w_drop_inc = w_drop_inc + 3'd1;
      else                          w_drop_inc = w_drop_inc;
    end
  end

  // Ready enable, round-robin pointers and drop counter.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_rdy_en <= 1'b0;
      r_drop   <= '0;
      for (int s = 0; s < NIN; s++) r_ptr[s] <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_drop   <= drop_sat_add(r_drop, w_drop_inc);
      for (int s = 0; s < NIN; s++) begin
        if (w_push[s]) begin
          r_ptr[s] <= (int'(w_grant[s]) == P - 1) ? '0 : w_grant[s] + PTRW'(1);
        end
      end
    end
  end

  genvar gs;
  generate
    for (gs = 0; gs < NIN; gs++) begin : g_stream
      lii_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (aclk),
        .rst_n   (arstn),
        .i_push  (w_push[gs]),
        .i_data  (w_push_data[gs]),
        .o_full  (w_full[gs]),
        .i_pop   (bus.k_tready[gs]),
        .o_valid (w_kvalid[gs]),
        .o_data  (w_kdata[gs])
      );
    end
  endgenerate

  // Pack stream heads onto the flat kernel data bus.
  always_comb begin
    for (int s = 0; s < NIN; s++) bus.k_tdata[s*DW +: DW] = w_kdata[s];
  end

  assign bus.k_tvalid = w_kvalid;
  assign ce           = ~|(bus.k_tready & ~w_kvalid);
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_lii_in_demux.sv
module tb_lii_in_demux;

  logic        clk;
  logic        arstn;
  logic        ce;
  logic [15:0] drop_count;
  int          n_chk;
  int          n_fail;

  lii_in_demux_if #(.NIN(4), .P(2), .PW(64), .DW(8)) bus ();

  lii_in_demux #(
    .NIN(4), .P(2), .PW(64), .DW(8), .DEPTH(4), .DST_BASE(8'h00)
  ) dut (
    .aclk       (clk),
    .arstn      (arstn),
    .bus        (bus),
    .ce         (ce),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [7:0]  d0, d1, t0, t1;
    logic [3:0]  kr;
    logic [1:0]  rdy;
    logic [3:0]  kv;
    logic [31:0] kd;
    logic        ce;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                              logic [7:0] t0, logic [7:0] t1, logic [3:0] kr,
                              logic [1:0] rdy, logic [3:0] kv, logic [31:0] kd,
                              logic ce_e, logic [15:0] drop);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.t0 = t0; r.t1 = t1; r.kr = kr;
    r.rdy = rdy; r.kv = kv; r.kd = kd; r.ce = ce_e; r.drop = drop;
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] t0, input logic [7:0] t1, input logic [3:0] kr);
    bus.lii_in_tvalid = v;
    bus.lii_in_dst    = {d1, d0};
    bus.lii_in_src    = {8'h11, 8'h10};
    bus.lii_in_tdata  = {56'hDEADBEEF000000, t1, 56'hDEADBEEF000000, t0};
    bus.k_tready      = kr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mask;
    n_chk  = 0;
    n_fail = 0;

    // Reset values
    arstn = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    #2;
    chk("rst_tready", {30'd0, bus.lii_in_tready}, 32'h0);
    chk("rst_kvalid", {28'd0, bus.k_tvalid}, 32'h0);
    chk("rst_ce_idle", {31'd0, ce}, 32'h1);
    chk("rst_drop", {16'd0, drop_count}, 32'h0);
    bus.k_tready = 4'b1111;
    #1;
    chk("rst_ce_ready", {31'd0, ce}, 32'h0);
    bus.k_tready = 4'b0000;
    @(posedge clk);
    #2 arstn = 1'b1;
    #1;
    chk("tready_before_edge", {30'd0, bus.lii_in_tready}, 32'h0);
    tick();

    // Table: round-robin, data slicing, ce, drops (state carries across rows)
    tbl[0]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd0);
    tbl[1]  = mk(2'b11, 8'h01, 8'h01, 8'h10, 8'h11, 4'b1111, 2'b01, 4'b0000, 32'h0,         1'b0, 16'd0);
    tbl[2]  = mk(2'b11, 8'h01, 8'h01, 8'h12, 8'h13, 4'b1111, 2'b10, 4'b0010, 32'h0000_1000, 1'b0, 16'd0);
    tbl[3]  = mk(2'b11, 8'h01, 8'h01, 8'h14, 8'h15, 4'b1111, 2'b01, 4'b0010, 32'h0000_1300, 1'b0, 16'd0);
    tbl[4]  = mk(2'b00, 8'h01, 8'h01, 8'h00, 8'h00, 4'b1111, 2'b11, 4'b0010, 32'h0000_1400, 1'b0, 16'd0);
    tbl[5]  = mk(2'b01, 8'h02, 8'h01, 8'hA5, 8'h00, 4'b1111, 2'b11, 4'b0000, 32'h0,         1'b0, 16'd0);
    tbl[6]  = mk(2'b00, 8'h02, 8'h01, 8'h00, 8'h00, 4'b1111, 2'b11, 4'b0100, 32'h00A5_0000, 1'b0, 16'd0);
    tbl[7]  = mk(2'b00, 8'h02, 8'h01, 8'h00, 8'h00, 4'b1000, 2'b11, 4'b0000, 32'h0,         1'b0, 16'd0);
    tbl[8]  = mk(2'b01, 8'h03, 8'h01, 8'h77, 8'h00, 4'b1000, 2'b11, 4'b0000, 32'h0,         1'b0, 16'd0);
    tbl[9]  = mk(2'b00, 8'h03, 8'h01, 8'h00, 8'h00, 4'b1000, 2'b11, 4'b1000, 32'h7700_0000, 1'b1, 16'd0);
    tbl[10] = mk(2'b01, 8'h20, 8'h01, 8'h01, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd0);
    tbl[11] = mk(2'b01, 8'h20, 8'h01, 8'h02, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd1);
    tbl[12] = mk(2'b01, 8'h20, 8'h01, 8'h03, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd2);
    tbl[13] = mk(2'b00, 8'h20, 8'h01, 8'h00, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd3);
    tbl[14] = mk(2'b11, 8'h20, 8'h04, 8'h00, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd3);
    tbl[15] = mk(2'b00, 8'h20, 8'h04, 8'h00, 8'h00, 4'b0000, 2'b11, 4'b0000, 32'h0,         1'b1, 16'd5);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].t0, tbl[i].t1, tbl[i].kr);
      #3;
      chk($sformatf("row%0d_tready", i), {30'd0, bus.lii_in_tready}, {30'd0, tbl[i].rdy});
      chk($sformatf("row%0d_kvalid", i), {28'd0, bus.k_tvalid}, {28'd0, tbl[i].kv});
      chk($sformatf("row%0d_ce", i), {31'd0, ce}, {31'd0, tbl[i].ce});
      chk($sformatf("row%0d_drop", i), {16'd0, drop_count}, {16'd0, tbl[i].drop});
      if (tbl[i].kv != 4'b0000) begin
        mask = '0;
        for (int s = 0; s < 4; s++) if (tbl[i].kv[s]) mask[s*8 +: 8] = 8'hFF;
        chk($sformatf("row%0d_kdata", i), bus.k_tdata & mask, tbl[i].kd & mask);
      end
      tick();
    end

    // Full FIFO on stream 0: 4 accepted, 5th blocked, pop re-enables next cycle
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 8'h00, 8'h01, 8'h30 + 8'(i), 8'h00, 4'b0000);
      #3;
      chk($sformatf("fill%0d_tready", i), {31'd0, bus.lii_in_tready[0]}, 32'h1);
      tick();
    end
    drive(2'b01, 8'h00, 8'h01, 8'h34, 8'h00, 4'b0000);
    #3;
    chk("full_tready", {31'd0, bus.lii_in_tready[0]}, 32'h0);
    chk("full_kvalid", {31'd0, bus.k_tvalid[0]}, 32'h1);
    chk("full_kdata_hold", {24'd0, bus.k_tdata[7:0]}, 32'h30);
    tick();
    bus.k_tready = 4'b0001;
    #3;
    chk("full_pop_tready", {31'd0, bus.lii_in_tready[0]}, 32'h0);
    chk("full_pop_kdata", {24'd0, bus.k_tdata[7:0]}, 32'h30);
    tick();
    bus.k_tready = 4'b0000;
    #3;
    chk("after_pop_tready", {31'd0, bus.lii_in_tready[0]}, 32'h1);
    chk("after_pop_kdata", {24'd0, bus.k_tdata[7:0]}, 32'h31);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(2'b00, 8'h00, 8'h01, 8'h00, 8'h00, 4'b0001);
      #3;
      chk($sformatf("drain%0d_kvalid", j), {31'd0, bus.k_tvalid[0]}, 32'h1);
      chk($sformatf("drain%0d_kdata", j), {24'd0, bus.k_tdata[7:0]}, 32'h31 + j);
      tick();
    end
    #3;
    chk("drained_kvalid", {31'd0, bus.k_tvalid[0]}, 32'h0);
    tick();

    // Reset with 3 beats buffered in stream 1
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 8'h00, 8'h01, 8'h00, 8'h50 + 8'(i), 4'b0000);
      #3;
      chk($sformatf("buf%0d_tready", i), {31'd0, bus.lii_in_tready[1]}, 32'h1);
      tick();
    end
    drive(2'b00, 8'h00, 8'h01, 8'h00, 8'h00, 4'b0000);
    #3;
    chk("buf_kvalid", {31'd0, bus.k_tvalid[1]}, 32'h1);
    chk("buf_kdata", {24'd0, bus.k_tdata[15:8]}, 32'h50);
    arstn = 1'b0;
    #1;
    chk("mid_rst_kvalid", {28'd0, bus.k_tvalid}, 32'h0);
    chk("mid_rst_tready", {30'd0, bus.lii_in_tready}, 32'h0);
    chk("mid_rst_drop", {16'd0, drop_count}, 32'h0);
    chk("mid_rst_ce", {31'd0, ce}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #2 arstn = 1'b1;
    #1;
    chk("post_rst_tready_low", {30'd0, bus.lii_in_tready}, 32'h0);
    tick();
    chk("post_rst_tready", {30'd0, bus.lii_in_tready}, 32'h3);
    bus.k_tready = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      #3;
      chk($sformatf("post_rst%0d_kvalid", j), {28'd0, bus.k_tvalid}, 32'h0);
      chk($sformatf("post_rst%0d_drop", j), {16'd0, drop_count}, 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lii_in_demux.md
LII_IN_DEMUX -- requirements
Module: lii_in_demux

Interface
REQ-001 SHALL have parameter NIN, default 4: number of logical kernel output streams, 1..8.
REQ-002 SHALL have parameter P, default 2: number of LII phy input channels, 1..4.
REQ-003 SHALL have parameter PW, default 64: phy packing width.
REQ-004 SHALL have parameter DW, default 8: logical stream data width, DW <= PW.
REQ-005 SHALL have parameter DEPTH, default 4: per-stream FIFO depth, power of two, >= 2.
REQ-006 SHALL have parameter DST_BASE, default 8'h00: dst value mapped to stream 0; stream s has ID DST_BASE+s.
REQ-007 SHALL have port aclk, input, 1: single clock; all logic is on its rising edge.
REQ-008 SHALL have port arstn, input, 1: reset, asynchronous assertion, active-low.
REQ-009 SHALL have port lii_in_tdata, input, P*PW: channel p occupies bits [p*PW +: PW].
REQ-010 SHALL have ports lii_in_tvalid (input) and lii_in_tready (output), each P bits: per-channel handshake.
REQ-011 SHALL have ports lii_in_src and lii_in_dst, input, P*8: per-channel source and destination IDs.
REQ-012 SHALL have port k_tdata, output, NIN*DW: stream s occupies bits [s*DW +: DW].
REQ-013 SHALL have ports k_tvalid (output) and k_tready (input), each NIN bits: kernel-side handshake.
REQ-014 SHALL have port ce, output, 1: kernel clock enable.
REQ-015 SHALL have port drop_count, output, 16: saturating count of dropped beats.

Function
REQ-016 SHALL transfer a beat on channel p when lii_in_tvalid[p] & lii_in_tready[p].
REQ-017 SHALL map a beat to stream s = dst - DST_BASE when 0 <= s < NIN; any other dst is unmapped.
REQ-018 SHALL drive lii_in_tready[p] = 1 for an unmapped beat, discard it, and increment drop_count, saturating at 16'hFFFF.
REQ-019 SHALL accept at most one beat per stream per cycle: the grant goes to the requesting channel chosen by a per-stream round-robin pointer.
REQ-020 SHALL drive lii_in_tready[p] for a mapped beat = grant[s]==p & ~full[s]; lii_in_tready SHALL NOT depend on lii_in_tvalid of the same channel.
REQ-021 SHALL advance pointer[s] to (granted p + 1) mod P only on an accepted beat; otherwise the pointer holds.
REQ-022 SHALL push lii_in_tdata[DW-1:0] of an accepted beat into FIFO s; the upper PW-DW bits and src are ignored.
REQ-023 SHALL present the beat on k_tvalid[s]/k_tdata the cycle after acceptance, giving one-cycle latency.
REQ-024 SHALL pop FIFO s when k_tvalid[s] & k_tready[s]; k_tdata SHALL hold stable while k_tvalid is high and k_tready is low.
REQ-025 SHALL block pushes on a full FIFO even if a pop occurs in the same cycle; simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-026 SHALL count drops from several channels in the same cycle by the number of unmapped accepted beats, with saturation.
REQ-027 SHALL compute ce = ~|(k_tready & ~k_tvalid), so the kernel is stalled while it waits on an empty stream.
REQ-028 SHALL keep the FIFO read/write pointers wrapping modulo DEPTH, with an extra MSB to distinguish full from empty.

Reset
REQ-029 SHALL, when arstn is low, clear all FIFOs to empty and set all round-robin pointers to 0 and drop_count to 0.
REQ-030 SHALL hold these reset output values: k_tvalid = 0, lii_in_tready = 0, ce = 0 if any k_tready is high (otherwise 1).
REQ-031 SHALL drop in-flight FIFO contents on a reset asserted mid-operation, with no partial beat emitted after deassertion.
REQ-032 SHALL keep lii_in_tready low until the first clock edge after arstn deasserts.

Structure
REQ-033 SHALL place the LII ID width (8), the drop counter width (16) and the saturation constant in the shared lii_pkg.
REQ-034 SHALL implement each stream buffer as one sub-module, lii_sync_fifo (parameters DW, DEPTH), instantiated NIN times by generate.

Verification
REQ-035 SHALL cover this scenario: P=2, ch0 and ch1 both send dst=1 continuously, k_tready=1 -> stream 1 receives alternating ch0, ch1, ch0 beats; each channel's tready is high every other cycle.
REQ-036 SHALL cover this scenario: ch0 sends dst=8'h20 (unmapped) for 3 beats -> tready is high every cycle, no k_tvalid, drop_count = 3.
REQ-037 SHALL cover this scenario: DEPTH=4, stream 0 k_tready=0, 5 beats offered -> 4 are accepted, then tready[0] goes low; one pop re-enables acceptance next cycle.
REQ-038 SHALL cover this scenario: beat tdata=64'hDEAD_BEEF_0000_00A5 to dst=2 -> k_tdata stream 2 = 8'hA5 one cycle after acceptance.
REQ-039 SHALL cover this scenario: k_tready[3]=1 with stream 3 empty -> ce=0; after a beat arrives -> ce=1 the same cycle k_tvalid[3] rises.
REQ-040 SHALL cover this scenario: arstn pulsed low with 3 beats buffered -> k_tvalid = 0 and drop_count = 0 afterwards, and no stale beat appears.
